clk_gate_ctrl: RTL and testbench

- Enable controller for the system's clock-gate cell; drives its enable input (CLK_EN) for the gated domain (ALU).
- Wakes the gated clock on request and returns a grant once the clock has run for WAKE_CYCLES.
- Keeps the clock running while the domain is busy, then shuts it off after IDLE_CYCLES of inactivity.
- Sits between the system controller (requester) and the clock-gate cell. Runs on the ungated reference clock.

---
 rtl/clk_gate_ctrl_pkg.sv | 22 ++
 rtl/clk_gate_ctrl.sv | 85 ++++++++
 tb/tb_clk_gate_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// ============================================================================
// clk_gate_ctrl_pkg : state encodings and default timing for clk_gate_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b11,
    ST_HOLD = 2'b10
  } state_t;

  localparam int DEFAULT_WAKE_CYCLES = 2;
  localparam int DEFAULT_IDLE_CYCLES = 8;
  localparam int DEFAULT_CNT_WIDTH   = 4;

endpackage

`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
// ============================================================================
// clk_gate_ctrl : enable controller for the ALU clock-gate cell (wake/hold/off)
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int WAKE_CYCLES = DEFAULT_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_busy,
  input  logic       i_force_on,
  output logic       o_clk_en,
  output logic       o_gnt,
  output logic [1:0] o_state
);

  localparam logic [CNT_WIDTH-1:0] c_wake_last = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_idle_last = CNT_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_clk_en;
  logic                 r_gnt;
  logic                 w_clk_en_nxt;
  logic                 w_gnt_nxt;

  // Counter defaults to zero so every state transition clears it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    unique case (r_state)
      ST_OFF: begin
        if (i_req || i_force_on) w_state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (r_cnt == c_wake_last) w_state_nxt = ST_ON;
        else                      w_cnt_nxt   = r_cnt + c_one;
      end
      ST_ON: begin
        if (!i_req && !i_busy && !i_force_on) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // REQ beats the timeout; BUSY/FORCE_ON beat it too by restarting it.
        if (i_req)                       w_state_nxt = ST_ON;
        else if (i_busy || i_force_on)   w_cnt_nxt   = '0;
        else if (r_cnt == c_idle_last)   w_state_nxt = ST_OFF;
        else                             w_cnt_nxt   = r_cnt + c_one;
      end
      default: w_state_nxt = ST_OFF;
    endcase
    w_clk_en_nxt = (w_state_nxt != ST_OFF);
    w_gnt_nxt    = (w_state_nxt == ST_ON);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
      r_gnt    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_gnt    <= w_gnt_nxt;
    end
  end

  assign o_clk_en = r_clk_en;
  assign o_gnt    = r_gnt;
  assign o_state  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
// ============================================================================
// tb_clk_gate_ctrl : directed scoreboard bench for clk_gate_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clk_gate_ctrl;

  // Expected outputs packed as {CLK_EN, GNT, STATE[1:0]}
  localparam logic [3:0] E_OFF  = 4'b0000;
  localparam logic [3:0] E_WAKE = 4'b1001;
  localparam logic [3:0] E_ON   = 4'b1111;
  localparam logic [3:0] E_HOLD = 4'b1010;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       busy;
  logic       force_on;
  logic       clk_en;
  logic       gnt;
  logic [1:0] state;

  logic [3:0] exp_q[$];
  int         vectors;
  int         miscompares;

  clk_gate_ctrl #(
    .WAKE_CYCLES (2),
    .IDLE_CYCLES (8),
    .CNT_WIDTH   (4)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_busy     (busy),
    .i_force_on (force_on),
    .o_clk_en   (clk_en),
    .o_gnt      (gnt),
    .o_state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r_n, input logic rq,
                      input logic bs, input logic fo, input logic [3:0] exp);
    logic [3:0] obs;
    logic [3:0] e;
    rst_n    = r_n;
    req      = rq;
    busy     = bs;
    force_on = fo;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    obs = {clk_en, gnt, state};
    e   = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic steps(input string tag, input int n, input logic rq,
                       input logic bs, input logic fo, input logic [3:0] exp);
    for (int i = 0; i < n; i++) step(tag, 1'b1, rq, bs, fo, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held with REQ high
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b1, 1'b0, 1'b0, E_OFF);

    // Wake latency: GNT on third edge after REQ sampled
    step ("wake_e0",  1'b1, 1'b1, 1'b0, 1'b0, E_WAKE);
    step ("wake_e1",  1'b1, 1'b1, 1'b0, 1'b0, E_WAKE);
    step ("wake_e2",  1'b1, 1'b1, 1'b0, 1'b0, E_ON);
    steps("on_req",   2, 1'b1, 1'b0, 1'b0, E_ON);
    steps("on_busy",  2, 1'b0, 1'b1, 1'b0, E_ON);

    // Idle shutdown: CLK_EN falls 8 edges after HOLD entry
    step ("hold_entry", 1'b1, 1'b0, 1'b0, 1'b0, E_HOLD);
    steps("hold_idle",  7, 1'b0, 1'b0, 1'b0, E_HOLD);
    step ("idle_off",   1'b1, 1'b0, 1'b0, 1'b0, E_OFF);
    steps("off_stay",   2, 1'b0, 1'b1, 1'b0, E_OFF);

    // Re-request at HOLD cnt=5
    steps("rereq_wake", 2, 1'b1, 1'b0, 1'b0, E_WAKE);
    step ("rereq_on",   1'b1, 1'b1, 1'b0, 1'b0, E_ON);
    step ("rereq_hold", 1'b1, 1'b0, 1'b0, 1'b0, E_HOLD);
    steps("rereq_cnt",  5, 1'b0, 1'b0, 1'b0, E_HOLD);
    step ("rereq_back", 1'b1, 1'b1, 1'b0, 1'b0, E_ON);

    // BUSY at terminal count restarts the idle timer
    step ("busy_hold",  1'b1, 1'b0, 1'b0, 1'b0, E_HOLD);
    steps("busy_cnt",   7, 1'b0, 1'b0, 1'b0, E_HOLD);
    step ("busy_term",  1'b1, 1'b0, 1'b1, 1'b0, E_HOLD);
    steps("busy_rerun", 7, 1'b0, 1'b0, 1'b0, E_HOLD);
    step ("busy_off",   1'b1, 1'b0, 1'b0, 1'b0, E_OFF);

    // Single-cycle REQ pulse still completes the wake
    step ("pulse_e0",   1'b1, 1'b1, 1'b0, 1'b0, E_WAKE);
    step ("pulse_e1",   1'b1, 1'b0, 1'b0, 1'b0, E_WAKE);
    step ("pulse_on",   1'b1, 1'b0, 1'b0, 1'b0, E_ON);
    step ("pulse_hold", 1'b1, 1'b0, 1'b0, 1'b0, E_HOLD);
    steps("pulse_cnt",  7, 1'b0, 1'b0, 1'b0, E_HOLD);
    step ("pulse_off",  1'b1, 1'b0, 1'b0, 1'b0, E_OFF);

    // REQ wins over timeout at terminal count
    steps("prio_wake",  2, 1'b1, 1'b0, 1'b0, E_WAKE);
    step ("prio_on",    1'b1, 1'b1, 1'b0, 1'b0, E_ON);
    step ("prio_hold",  1'b1, 1'b0, 1'b0, 1'b0, E_HOLD);
    steps("prio_cnt",   7, 1'b0, 1'b0, 1'b0, E_HOLD);
    step ("prio_req",   1'b1, 1'b1, 1'b0, 1'b0, E_ON);

    // FORCE_ON: keeps ON, and keeps HOLD alive indefinitely
    steps("force_on",   2, 1'b0, 1'b0, 1'b1, E_ON);
    step ("force_drop", 1'b1, 1'b0, 1'b0, 1'b0, E_HOLD);
    steps("force_hold", 12, 1'b0, 1'b0, 1'b1, E_HOLD);
    steps("force_rel",  7, 1'b0, 1'b0, 1'b0, E_HOLD);
    step ("force_off",  1'b1, 1'b0, 1'b0, 1'b0, E_OFF);
    steps("force_wake", 2, 1'b0, 1'b0, 1'b1, E_WAKE);
    steps("force_keep", 3, 1'b0, 1'b0, 1'b1, E_ON);

    // Reset mid-operation drops CLK_EN on the next edge
    step ("rst_mid",    1'b0, 1'b1, 1'b0, 1'b1, E_OFF);
    step ("rst_rewake", 1'b1, 1'b1, 1'b0, 1'b0, E_WAKE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
